// File: rtl/usb_rx_line_assembler_if.sv
// Byte-stream and held-line port bundle between usb_pipeline, the line
// assembler, and the downstream command consumer.
interface usb_rx_line_assembler_if #(
   parameter int MAX_LEN = 16,
   parameter int ADDR_W  = 4
);
   logic [7:0]        usb_rx_data;
   logic              usb_rx_valid;
   logic              usb_rx_ready;
   logic              line_valid;
   logic              line_err;
   logic [ADDR_W:0]   line_len;
   logic [ADDR_W-1:0] line_rd_addr;
   logic [7:0]        line_rd_data;
   logic              line_ack;
   logic [7:0]        line_count;

   modport master (
      output usb_rx_data, usb_rx_valid, line_rd_addr, line_ack,
      input  usb_rx_ready, line_valid, line_err, line_len, line_rd_data, line_count
   );

   modport slave (
      input  usb_rx_data, usb_rx_valid, line_rd_addr, line_ack,
      output usb_rx_ready, line_valid, line_err, line_len, line_rd_data, line_count
   );
endinterface

// File: rtl/usb_rx_line_assembler.sv
// Assembles CR-stripped, LF-terminated lines from the USB receive stream and
// holds each one (with backpressure) until the command consumer acks it.
module usb_rx_line_assembler #(
   parameter int MAX_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input logic                   CLK,
   input logic                   RST_N,
   usb_rx_line_assembler_if.slave bus
);
   typedef enum logic [1:0] {S_COLLECT, S_DISCARD, S_HOLD} state_t;

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(MAX_LEN);
   localparam logic [7:0]      LF   = 8'h0A;
   localparam logic [7:0]      CR   = 8'h0D;

   state_t          state, state_nxt;
   logic [ADDR_W:0] cnt, cnt_nxt, len_q, len_nxt;
   logic            rdy_q, rdy_nxt, vld_q, vld_nxt, err_q, err_nxt;
   logic [7:0]      lcnt_q, lcnt_nxt;
   logic            wr_en, xfer, is_lf, is_cr;
   logic [7:0]      mem [MAX_LEN];

   assign xfer  = bus.usb_rx_valid && rdy_q;
   assign is_lf = (bus.usb_rx_data == LF);
   assign is_cr = (bus.usb_rx_data == CR);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_COLLECT;
         cnt    <= '0;
         len_q  <= '0;
         rdy_q  <= 1'b0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
         lcnt_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         len_q  <= len_nxt;
         rdy_q  <= rdy_nxt;
         vld_q  <= vld_nxt;
         err_q  <= err_nxt;
         lcnt_q <= lcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len_q;
      vld_nxt   = vld_q;
      err_nxt   = err_q;
      lcnt_nxt  = lcnt_q;
      wr_en     = 1'b0;
      case (state)
         S_COLLECT: begin
            if (xfer) begin
               if (is_lf) begin
                  state_nxt = S_HOLD;
                  len_nxt   = cnt;
                  vld_nxt   = 1'b1;
                  lcnt_nxt  = lcnt_q + 8'd1;
               end else if (!is_cr) begin
                  if (cnt == FULL) begin
                     err_nxt   = 1'b1;
                     state_nxt = S_DISCARD;
                  end else begin
                     wr_en   = 1'b1;
                     cnt_nxt = cnt + (ADDR_W+1)'(1);
                  end
               end
            end
         end
         S_DISCARD: begin
            if (xfer && is_lf) begin
               state_nxt = S_HOLD;
               len_nxt   = FULL;
               vld_nxt   = 1'b1;
               lcnt_nxt  = lcnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (bus.line_ack) begin
               state_nxt = S_COLLECT;
               cnt_nxt   = '0;
               vld_nxt   = 1'b0;
               err_nxt   = 1'b0;
            end
         end
         default: state_nxt = S_COLLECT;
      endcase
      // Ready is registered from the next state, so it drops on the LF edge
      // and rises on the ack edge with no extra cycle.
      rdy_nxt = (state_nxt != S_HOLD);
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[cnt[ADDR_W-1:0]] <= bus.usb_rx_data;
   end

   assign bus.usb_rx_ready = rdy_q;
   assign bus.line_valid   = vld_q;
   assign bus.line_err     = err_q;
   assign bus.line_len     = len_q;
   assign bus.line_count   = lcnt_q;
   assign bus.line_rd_data = mem[bus.line_rd_addr];
endmodule

// File: tb/tb_usb_rx_line_assembler.sv
// Scoreboard bench: stimulus pushes the expected line, a monitor checks each
// held line, reads it back, and acks it after a chosen delay.
`timescale 1ns/1ps
module tb_usb_rx_line_assembler;
   localparam int MAX_LEN = 16;
   localparam int ADDR_W  = 4;

   typedef struct packed {
      logic [MAX_LEN-1:0][7:0] data;
      logic [7:0]              cnt;
      logic [ADDR_W:0]         len;
      logic                    err;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   usb_rx_line_assembler_if #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) bus ();

   usb_rx_line_assembler #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
   );

   always #31.25 CLK = ~CLK;

   int   vectors = 0, miscompares = 0;
   int   cyc = 0, lf_edge = 0, model_cnt = 0;
   int   fixed_delay = -1;
   bit   gaps_en = 1'b0, mon_busy = 1'b0;
   exp_t exp_q[$];

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic report();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
   endtask

   initial begin
      repeat (60000) @(posedge CLK);
      miscompares++;
      $display("FAIL watchdog: cycle budget exhausted, pending=%0d", exp_q.size());
      report();
      $finish;
   end

   // One byte is consumed when valid is driven and ready is already high,
   // since ready cannot change before the following rising edge.
   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      while (!done) begin
         @(negedge CLK);
         if (gaps_en && $urandom_range(3) == 0) begin
            bus.usb_rx_valid = 1'b0;
            bus.usb_rx_data  = 8'($urandom);
         end else begin
            bus.usb_rx_valid = 1'b1;
            bus.usb_rx_data  = b;
            if (bus.usb_rx_ready) begin
               done = 1'b1;
               if (b == 8'h0A) lf_edge = cyc + 1;
            end
         end
      end
   endtask

   task automatic idle();
      @(negedge CLK);
      bus.usb_rx_valid = 1'b0;
   endtask

   // Reference: keep non-CR bytes before the LF; anything past MAX_LEN is
   // lost and flags the line as truncated.
   task automatic send_line(input logic [7:0] bytes[$]);
      exp_t e;
      int   n = 0;
      e = '0;
      for (int i = 0; i < bytes.size() - 1; i++) begin
         if (bytes[i] == 8'h0D) continue;
         if (n < MAX_LEN) e.data[n] = bytes[i];
         n++;
      end
      e.err     = (n > MAX_LEN);
      e.len     = (ADDR_W+1)'(e.err ? MAX_LEN : n);
      model_cnt = (model_cnt + 1) % 256;
      e.cnt     = 8'(model_cnt);
      exp_q.push_back(e);
      foreach (bytes[i]) send_byte(bytes[i]);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || mon_busy); i++) @(negedge CLK);
      chk("drain_pending", exp_q.size() + int'(mon_busy), 0);
   endtask

   initial begin : monitor
      exp_t e;
      int   d;
      forever begin
         @(negedge CLK);
         if (RST_N && bus.line_valid) begin
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               chk("unexpected_line", 1, 0);
               e = '0;
            end else begin
               e = exp_q.pop_front();
            end
            chk("lf_latency", cyc, lf_edge);
            chk("line_len", bus.line_len, e.len);
            chk("line_err", bus.line_err, e.err);
            chk("line_count", bus.line_count, e.cnt);
            for (int i = 0; i < int'(e.len); i++) begin
               bus.line_rd_addr = ADDR_W'(i);
               #1;
               chk($sformatf("rd_data[%0d]", i), bus.line_rd_data, e.data[i]);
            end
            d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(4));
            @(negedge CLK);
            repeat (d) begin
               @(negedge CLK);
               chk("hold_ready_low", bus.usb_rx_ready, 0);
               chk("hold_valid_high", bus.line_valid, 1);
            end
            bus.line_ack = 1'b1;
            @(posedge CLK);
            #1;
            bus.line_ack = 1'b0;
            chk("ack_valid_low", bus.line_valid, 0);
            chk("ack_ready_high", bus.usb_rx_ready, 1);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : stim
      logic [7:0] q[$];
      int n;
      bus.usb_rx_valid = 1'b0;
      bus.usb_rx_data  = 8'h00;
      bus.line_rd_addr = '0;
      bus.line_ack     = 1'b0;
      #100;
      chk("rst_ready", bus.usb_rx_ready, 0);
      chk("rst_valid", bus.line_valid, 0);
      chk("rst_err", bus.line_err, 0);
      chk("rst_len", bus.line_len, 0);
      chk("rst_count", bus.line_count, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("ready_after_rst", bus.usb_rx_ready, 1);

      q = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111, 8'd33, 8'h0A};
      send_line(q);
      q = '{8'd65, 8'd66, 8'h0D, 8'h0A};
      send_line(q);
      // Exactly MAX_LEN data bytes is a full line, not an overflow.
      q.delete();
      for (int i = 0; i < MAX_LEN; i++) q.push_back(8'h61 + 8'(i));
      q.push_back(8'h0A);
      send_line(q);
      q.delete();
      for (int i = 0; i < 20; i++) q.push_back(8'h41 + 8'(i));
      q.push_back(8'h0A);
      fixed_delay = 10;
      send_line(q);
      // Byte 'X' waits on the bus throughout the hold of the truncated line.
      q = '{8'h58, 8'h0A};
      send_line(q);
      fixed_delay = -1;
      idle();
      drain();

      q = '{8'h0A};
      for (int i = 0; i < 256; i++) send_line(q);
      idle();
      drain();

      gaps_en = 1'b1;
      for (int l = 0; l < 40; l++) begin
         q.delete();
         n = $urandom_range(20);
         for (int i = 0; i < n; i++)
            q.push_back(($urandom_range(7) == 0) ? 8'h0D : 8'($urandom_range(8'h20, 8'h7E)));
         q.push_back(8'h0A);
         send_line(q);
      end
      idle();
      drain();
      gaps_en = 1'b0;

      q = '{8'h58, 8'h59, 8'h5A};
      foreach (q[i]) send_byte(q[i]);
      idle();
      #2;
      RST_N = 1'b0;
      #1;
      chk("midrst_ready", bus.usb_rx_ready, 0);
      chk("midrst_valid", bus.line_valid, 0);
      chk("midrst_err", bus.line_err, 0);
      chk("midrst_len", bus.line_len, 0);
      chk("midrst_count", bus.line_count, 0);
      model_cnt = 0;
      @(negedge CLK);
      RST_N = 1'b1;
      q = '{8'd81, 8'h0A};
      send_line(q);
      idle();
      drain();

      report();
      $finish;
   end
endmodule
